// File: rtl/r4u3_tw_ctrl_if.sv
// r4u3_tw_ctrl_if -- bus bundle for the unit-3 twiddle sequencer.
//   din_valid/din_sop : butterfly output sample strobe and frame start
//   rom_addr/rom_data : combinational twiddle ROM port
//   tw_*              : registered twiddle toward the complex multiplier
//   sop_err           : sticky missing-frame-start flag
//   ifft              : inverse-transform select (only with R4U3_IFFT_EN)
// slave modport is the sequencer's view; master is the surrounding logic.
`ifndef COEF_WIDTH
`define COEF_WIDTH 16
`endif

interface r4u3_tw_ctrl_if #(
   parameter int CW = `COEF_WIDTH
);
   logic              din_valid;
   logic              din_sop;
   logic [6:0]        rom_addr;
   logic [2*CW-1:0]   rom_data;
   logic              tw_valid;
   logic [2*CW-1:0]   tw_data;
   logic              tw_sop;
   logic              tw_eop;
   logic              sop_err;
`ifdef R4U3_IFFT_EN
   logic              ifft;
`endif

   modport slave (
      input  din_valid, din_sop, rom_data,
`ifdef R4U3_IFFT_EN
      input  ifft,
`endif
      output rom_addr, tw_valid, tw_data, tw_sop, tw_eop, sop_err
   );

   modport master (
      output din_valid, din_sop, rom_data,
`ifdef R4U3_IFFT_EN
      output ifft,
`endif
      input  rom_addr, tw_valid, tw_data, tw_sop, tw_eop, sop_err
   );
endinterface

// File: rtl/r4u3_tw_ctrl.sv
// r4u3_tw_ctrl -- twiddle-factor sequencer for pipeline FFT radix-4 unit 3.
// Counts valid samples per 4L-sample frame as (leg k, position n), drives
// the twiddle ROM address k*n (built incrementally, no multiplier) and
// registers the returned coefficient so it lines up with its sample one
// cycle later at the multiplier.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : r4u3_tw_ctrl_if.slave (sample strobe in, ROM port, twiddle out)
// Optional feature macro R4U3_IFFT_EN: adds bus.ifft; when high the
// imaginary part is negated with saturation of the most negative value.
`ifndef COEF_WIDTH
`define COEF_WIDTH 16
`endif

module r4u3_tw_ctrl #(
   parameter int LOG2_L = 5,
   parameter int CW     = `COEF_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   r4u3_tw_ctrl_if.slave     bus
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]        state;
   logic [1:0]        k;
   logic [LOG2_L-1:0] n;
   logic [6:0]        acc;

   logic              tw_valid_q, tw_sop_q, tw_eop_q, sop_err_q;
   logic [2*CW-1:0]   tw_data_q;
   logic [2*CW-1:0]   tw_next;

   logic sample, start, n_wrap, last;

   assign sample = bus.din_valid;
   assign start  = bus.din_valid & bus.din_sop;
   assign n_wrap = (n == {LOG2_L{1'b1}});
   assign last   = (k == 2'd3) && n_wrap;

   // A frame start always uses address 0, even if it aborts a running frame.
   assign bus.rom_addr = (state == RUN && !start) ? acc : 7'd0;

`ifdef R4U3_IFFT_EN
   logic [CW-1:0] im, im_neg;
   always_comb begin
      im = bus.rom_data[CW-1:0];
      // -(-2^(CW-1)) is not representable; clamp to the largest positive.
      if (im == {1'b1, {(CW-1){1'b0}}})
         im_neg = {1'b0, {(CW-1){1'b1}}};
      else
         im_neg = -im;
      tw_next = bus.ifft ? {bus.rom_data[2*CW-1:CW], im_neg} : bus.rom_data;
   end
`else
   assign tw_next = bus.rom_data;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         k          <= '0;
         n          <= '0;
         acc        <= '0;
         tw_valid_q <= 1'b0;
         tw_sop_q   <= 1'b0;
         tw_eop_q   <= 1'b0;
         tw_data_q  <= '0;
         sop_err_q  <= 1'b0;
      end else begin
         tw_valid_q <= sample;
         tw_sop_q   <= start;
         // An aborted frame never reaches its last sample, so no eop for it.
         tw_eop_q   <= sample & ~bus.din_sop & (state == RUN) & last;
         if (sample) begin
            tw_data_q <= tw_next;
            if (bus.din_sop) begin
               state <= RUN;
               k     <= '0;
               n     <= LOG2_L'(1);
               acc   <= '0;
            end else if (state == IDLE) begin
               // Orphan sample: served with address 0, frame not started.
               sop_err_q <= 1'b1;
            end else if (last) begin
               state <= IDLE;
               k     <= '0;
               n     <= '0;
               acc   <= '0;
            end else if (n_wrap) begin
               k   <= k + 2'd1;
               n   <= '0;
               acc <= '0;
            end else begin
               // acc tracks k*n: one more step along leg k adds k.
               n   <= n + LOG2_L'(1);
               acc <= acc + {5'd0, k};
            end
         end
      end
   end

   assign bus.tw_valid = tw_valid_q;
   assign bus.tw_data  = tw_data_q;
   assign bus.tw_sop   = tw_sop_q;
   assign bus.tw_eop   = tw_eop_q;
   assign bus.sop_err  = sop_err_q;

endmodule

// File: tb/tb_r4u3_tw_ctrl.sv
// Bench for r4u3_tw_ctrl at LOG2_L = 5 (frame 128, L = 32), CW = 16.
// Reference model tracks the sample index within a frame and derives the
// expected ROM address as (idx / L) * (idx % L).
module tb_r4u3_tw_ctrl;
   localparam int CW = 16;
   localparam int L  = 32;
   localparam int FR = 4 * L;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   r4u3_tw_ctrl_if #(.CW(CW)) bus();

   r4u3_tw_ctrl #(.LOG2_L(5), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ROM model, with an override for directed coefficient values.
   bit          rom_ovr_en = 1'b0;
   logic [31:0] rom_ovr    = '0;

   function automatic logic [31:0] rom_val(input int a);
      int re, im;
      if (rom_ovr_en) return rom_ovr;
      re = (a * 37 + 257) % 65536;
      im = (32768 + a * 251) % 65536;
      return {re[15:0], im[15:0]};
   endfunction

   assign bus.rom_data = rom_val(int'(bus.rom_addr));

   function automatic logic [31:0] tw_exp(input logic [31:0] r, input bit inv);
      int im;
      if (!inv) return r;
      im = int'($signed(r[15:0]));
      im = -im;
      if (im > 32767) im = 32767;
      return {r[31:16], im[15:0]};
   endfunction

   int ntests = 0;
   int nfail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   int idx      = 0;
   bit in_frame = 1'b0;
   bit m_err    = 1'b0;
   bit ifft_v   = 1'b0;
   bit ifft_fix = 1'b0;

   function automatic int addr_of(input int i);
      return (i / L) * (i % L);
   endfunction

   task automatic step(input bit v, input bit s);
      int          exp_a;
      logic [31:0] exp_d;
      bit          e_sop, e_eop;
      @(negedge clk);
`ifdef R4U3_IFFT_EN
      ifft_v   = ifft_fix ? 1'b1 : bit'($urandom_range(0, 1));
      bus.ifft = ifft_v;
`else
      ifft_v   = 1'b0;
`endif
      bus.din_valid = v;
      bus.din_sop   = s;
      #1;
      exp_a = (v && s) ? 0 : (in_frame ? addr_of(idx + 1) : 0);
      chk("rom_addr", 64'(bus.rom_addr), 64'(exp_a));
      exp_d = tw_exp(rom_val(exp_a), ifft_v);
      e_sop = 1'b0;
      e_eop = 1'b0;
      if (v) begin
         if (s) begin
            idx = 0; in_frame = 1'b1; e_sop = 1'b1;
         end else if (in_frame) begin
            idx++;
            if (idx == FR - 1) begin e_eop = 1'b1; in_frame = 1'b0; end
         end else begin
            m_err = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      chk("tw_valid", 64'(bus.tw_valid), 64'(v));
      if (v) begin
         chk("tw_data", 64'(bus.tw_data), 64'(exp_d));
         chk("tw_sop",  64'(bus.tw_sop),  64'(e_sop));
         chk("tw_eop",  64'(bus.tw_eop),  64'(e_eop));
      end
      chk("sop_err", 64'(bus.sop_err), 64'(m_err));
   endtask

   task automatic run_frame(input bit rand_valid);
      int cnt;
      step(1'b1, 1'b1);
      cnt = 1;
      while (cnt < FR) begin
         bit v;
         v = rand_valid ? bit'($urandom_range(0, 1)) : 1'b1;
         step(v, 1'b0);
         if (v) cnt++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.din_valid = 1'b0;
      bus.din_sop   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idx = 0; in_frame = 1'b0; m_err = 1'b0;
   endtask

   initial begin
      bus.din_valid = 1'b0;
      bus.din_sop   = 1'b0;
`ifdef R4U3_IFFT_EN
      bus.ifft = 1'b0;
`endif
      #12;
      chk("rst_tw_valid", 64'(bus.tw_valid), 64'd0);
      chk("rst_tw_data",  64'(bus.tw_data),  64'd0);
      chk("rst_tw_sop",   64'(bus.tw_sop),   64'd0);
      chk("rst_tw_eop",   64'(bus.tw_eop),   64'd0);
      chk("rst_sop_err",  64'(bus.sop_err),  64'd0);
      chk("rst_rom_addr", 64'(bus.rom_addr), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Continuous frame, then idle: FSM must be back in IDLE.
      run_frame(1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Pseudo-random valid pattern, then two back-to-back frames.
      run_frame(1'b1);
      run_frame(1'b0);
      run_frame(1'b0);

      // Restart mid-frame at sample 70.
      step(1'b1, 1'b1);
      for (int i = 1; i < 70; i++) step(1'b1, 1'b0);
      for (int i = 0; i < FR; i++) step(1'b1, i == 0);
      step(1'b0, 1'b0);

      // Orphan sample: sticky error survives later good frames.
      step(1'b1, 1'b0);
      run_frame(1'b0);
      run_frame(1'b1);
      step(1'b0, 1'b0);

      // Reset while sample 40 is on the bus.
      do_reset();
      step(1'b1, 1'b1);
      for (int i = 1; i < 40; i++) step(1'b1, 1'b0);
      @(negedge clk);
      bus.din_valid = 1'b1;
      bus.din_sop   = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("mrst_tw_valid", 64'(bus.tw_valid), 64'd0);
      chk("mrst_tw_data",  64'(bus.tw_data),  64'd0);
      chk("mrst_tw_sop",   64'(bus.tw_sop),   64'd0);
      chk("mrst_tw_eop",   64'(bus.tw_eop),   64'd0);
      chk("mrst_sop_err",  64'(bus.sop_err),  64'd0);
      chk("mrst_rom_addr", 64'(bus.rom_addr), 64'd0);
      @(negedge clk);
      bus.din_valid = 1'b0;
      rst = 1'b0;
      idx = 0; in_frame = 1'b0; m_err = 1'b0;
      run_frame(1'b0);

`ifdef R4U3_IFFT_EN
      ifft_fix   = 1'b1;
      rom_ovr_en = 1'b1;
      rom_ovr    = 32'h5A5A_1234;
      step(1'b1, 1'b1);
      chk("ifft_1234", 64'(bus.tw_data), 64'h5A5A_EDCC);
      rom_ovr    = 32'hC3C3_8000;
      step(1'b1, 1'b0);
      chk("ifft_8000", 64'(bus.tw_data), 64'hC3C3_7FFF);
      rom_ovr_en = 1'b0;
      ifft_fix   = 1'b0;
      step(1'b0, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
